wave_capture: RTL and testbench
===============================

// Module: wave_capture
// PURPOSE
//   Consumes the music player's output stream (sample_out / new_sample_generated).
//   Triggers on a rising zero crossing and captures 2^ADDR_WIDTH samples into one
//   half of a ping-pong display RAM, scaled to 8-bit unsigned.
//   Hands the full half to the wave display by flipping read_index once the
//   display reports idle.
// PARAMETERS
//   ADDR_WIDTH    8   log2 of samples per capture (256)
//   DEC_SHIFT     2   log2 decimation ratio; used only with WAVE_CAPTURE_DECIMATE_EN
// PORTS
//   clk                 in   1             system clock, all logic on rising edge
//   reset               in   1             asynchronous, active-low reset
//   new_sample_ready    in   1             one-cycle strobe: new_sample_in valid
//   new_sample_in       in   16            signed two's-complement sample
//   wave_display_idle   in   1             display has finished reading its half
//   write_address       out  ADDR_WIDTH+1  {~read_index, index}
//   write_enable        out  1             one-cycle RAM write strobe
//   write_sample        out  8             {~s[15], s[14:8]}, unsigned, 0 -> 0x80
//   read_index          out  1             RAM half owned by the display
// BEHAVIOUR
//   - Reset (reset==0, async): state=ARMED, index=0, prev_sample=0, read_index=0.
//     write_enable=0, write_address=0, write_sample=0. All outputs registered.
//   - prev_sample <= new_sample_in on every new_sample_ready, in every state.
//   - Trigger condition: prev_sample[15]==1 && new_sample_in[15]==0.
//     A value of exactly 0 counts as non-negative, so -1 -> 0 triggers.
//   - ARMED:
//       - new_sample_ready with trigger -> ACTIVE.
//       - The trigger sample is written at index 0; index becomes 1.
//       - No trigger: no write, stay ARMED.
//   - ACTIVE:
//       - Each accepted new_sample_ready writes at the current index, then index++.
//       - The write that lands at index 2^ADDR_WIDTH-1 -> WAIT; index wraps to 0.
//       - The trigger condition is ignored in ACTIVE.
//   - WAIT:
//       - No writes.
//       - wave_display_idle==1 -> read_index toggles, state -> ARMED.
//       - A simultaneous new_sample_ready updates prev_sample only; it cannot trigger.
//   - wave_display_idle is ignored in ARMED and ACTIVE.
//   - Latency: write_enable/address/sample valid in the cycle after the accepted
//     new_sample_ready. write_enable is high for exactly one cycle per write.
//   - Strobes on consecutive cycles are each handled: no sample is dropped or
//     merged. write_enable may be high on back-to-back cycles.
//   - The half being written is always ~read_index. read_index changes only on
//     the WAIT -> ARMED transition, never mid-capture.
//   - Reset mid-capture: the partial capture is abandoned and the reset state
//     applies; the next trigger restarts at index 0 in half 1.
// CONFIGURATION
//   WAVE_CAPTURE_DECIMATE_EN defined:
//     - A DEC_SHIFT-bit phase counter is cleared to 0 on the trigger.
//     - It increments on each new_sample_ready in ACTIVE.
//     - In ACTIVE, only strobes arriving with phase==0 are written; others are
//       counted but not written.
//     - A capture therefore spans 2^(ADDR_WIDTH+DEC_SHIFT) input samples.
//     - Trigger detection in ARMED still examines every sample.
//   Not defined: every sample in ACTIVE is written; phase counter absent.
// TESTING
//   T1 reset: drive reset=0 mid-stream -> all outputs 0 immediately; after
//      release, positive-only samples produce no write.
//   T2 trigger: samples -100, -1, 0, 5 ->
//      - the sample 0 writes addr 0x100, data 0x80;
//      - the sample 5 writes addr 0x101, data 0x80.
//   T3 fill: trigger then 300 strobes ->
//      - exactly 256 writes, addr 0x100..0x1FF;
//      - no further writes while wave_display_idle=0.
//   T4 handoff: in WAIT, pulse wave_display_idle together with new_sample_ready ->
//      - read_index 0 -> 1 next cycle, no write;
//      - the next trigger writes addr 0x000.
//   T5 reset mid-ACTIVE at index 100 -> ARMED, read_index 0; the next capture
//      starts at addr 0x100.
//   T6 with WAVE_CAPTURE_DECIMATE_EN, DEC_SHIFT=2 ->
//      - trigger then 1024 strobes give 256 writes;
//      - input samples 0, 4, 8, ... land at indices 0, 1, 2, ...

Source files
------------

// File: rtl/wave_capture_if.sv
// wave_capture_if: sample-stream input and display-RAM write port of wave_capture
//   new_sample_ready/new_sample_in  incoming sample strobe and signed sample
//   wave_display_idle               display has finished reading its half
//   write_address/enable/sample     display RAM write port
//   read_index                      RAM half owned by the display
interface wave_capture_if #(
    parameter int ADDR_WIDTH = 8
);
    logic                  new_sample_ready;
    logic [15:0]           new_sample_in;
    logic                  wave_display_idle;
    logic [ADDR_WIDTH:0]   write_address;
    logic                  write_enable;
    logic [7:0]            write_sample;
    logic                  read_index;

    modport master (
        output new_sample_ready, new_sample_in, wave_display_idle,
        input  write_address, write_enable, write_sample, read_index
    );

    modport slave (
        input  new_sample_ready, new_sample_in, wave_display_idle,
        output write_address, write_enable, write_sample, read_index
    );
endinterface

// File: rtl/wave_capture.sv
// wave_capture: zero-crossing triggered capture into a ping-pong display RAM
//   clk    system clock, rising edge
//   reset  asynchronous, active-low
//   bus    wave_capture_if.slave: sample stream in, RAM write port and read_index out
//   Optional feature macro: WAVE_CAPTURE_DECIMATE_EN (write one of every 2^DEC_SHIFT samples)
module wave_capture #(
    parameter int ADDR_WIDTH = 8,
    parameter int DEC_SHIFT  = 2
) (
    input  logic          clk,
    input  logic          reset,
    wave_capture_if.slave bus
);
    typedef enum logic [1:0] {ARMED, ACTIVE, WAIT} state_t;

    localparam logic [ADDR_WIDTH-1:0] LAST = '1;

    if (DEC_SHIFT < 1) begin : g_bad_dec
        $error("DEC_SHIFT must be at least 1");
    end

    state_t                state, state_n;
    logic [ADDR_WIDTH-1:0] index, index_n;
    logic [15:0]           prev_sample;
    logic                  read_index_n;
    logic                  write_n;
    logic                  trigger;
    logic                  take;

    assign trigger = prev_sample[15] & ~bus.new_sample_in[15];

`ifdef WAVE_CAPTURE_DECIMATE_EN
    logic [DEC_SHIFT-1:0] phase, phase_n;
    assign take = phase == '0;
`else
    assign take = 1'b1;
`endif

    always_comb begin
        state_n      = state;
        index_n      = index;
        read_index_n = bus.read_index;
        write_n      = 1'b0;
`ifdef WAVE_CAPTURE_DECIMATE_EN
        phase_n      = phase;
`endif
        case (state)
            ARMED: if (bus.new_sample_ready && trigger) begin
                state_n = ACTIVE;
                write_n = 1'b1;
                index_n = ADDR_WIDTH'(1);
`ifdef WAVE_CAPTURE_DECIMATE_EN
                // the trigger sample itself is phase 0, so the next one is phase 1
                phase_n = DEC_SHIFT'(1);
`endif
            end
            ACTIVE: if (bus.new_sample_ready) begin
`ifdef WAVE_CAPTURE_DECIMATE_EN
                phase_n = phase + 1'b1;
`endif
                if (take) begin
                    write_n = 1'b1;
                    index_n = index + 1'b1;
                    state_n = index == LAST ? WAIT : ACTIVE;
                end
            end
            default: if (bus.wave_display_idle) begin
                read_index_n = ~bus.read_index;
                state_n      = ARMED;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state             <= ARMED;
            index             <= '0;
            prev_sample       <= '0;
            bus.read_index    <= 1'b0;
            bus.write_enable  <= 1'b0;
            bus.write_address <= '0;
            bus.write_sample  <= '0;
`ifdef WAVE_CAPTURE_DECIMATE_EN
            phase             <= '0;
`endif
        end else begin
            state            <= state_n;
            index            <= index_n;
            bus.read_index   <= read_index_n;
            bus.write_enable <= write_n;
`ifdef WAVE_CAPTURE_DECIMATE_EN
            phase            <= phase_n;
`endif
            if (bus.new_sample_ready)
                prev_sample <= bus.new_sample_in;
            // the writing half is the one the display does not own
            if (write_n) begin
                bus.write_address <= {~bus.read_index, state == ARMED ? '0 : index};
                bus.write_sample  <= {~bus.new_sample_in[15], bus.new_sample_in[14:8]};
            end
        end
    end
endmodule

// File: tb/tb_wave_capture.sv
// tb_wave_capture: table vectors plus scoreboard-checked capture sequences for wave_capture
module tb_wave_capture;
`ifdef WAVE_CAPTURE_DECIMATE_EN
    localparam int DEC = 4;
`else
    localparam int DEC = 1;
`endif

    typedef struct packed {
        logic       we;
        logic [8:0] addr;
        logic [7:0] data;
        logic       ri;
    } exp_t;

    typedef struct {
        logic        rdy;
        logic [15:0] s;
        logic        idle;
        logic        we;
        logic [8:0]  addr;
        logic [7:0]  data;
    } vec_t;

    logic clk;
    logic reset;
    wave_capture_if #(.ADDR_WIDTH(8)) bus ();

    wave_capture #(.ADDR_WIDTH(8), .DEC_SHIFT(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk;
    int n_fail;
    int n_writes;
    logic [8:0] last_addr;
    exp_t sb[$];

    int         m_state;
    logic [7:0] m_idx;
    logic [15:0] m_prev;
    logic       m_ri;
    int         m_ph;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic async_reset();
        @(posedge clk);
        #3 reset = 1'b0;
        bus.new_sample_ready = 1'b0;
        bus.wave_display_idle = 1'b0;
        #1;
        chk("rst_we", bus.write_enable, 0);
        chk("rst_addr", bus.write_address, 0);
        chk("rst_data", bus.write_sample, 0);
        chk("rst_ri", bus.read_index, 0);
        m_state = 0;
        m_idx = '0;
        m_prev = '0;
        m_ri = 1'b0;
        m_ph = 0;
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b1;
    endtask

    task automatic step(input logic rdy, input logic [15:0] s, input logic idle);
        exp_t e;
        logic trig;
        e.we = 1'b0;
        e.addr = '0;
        e.data = {~s[15], s[14:8]};
        trig = m_prev[15] && !s[15];
        if (m_state == 2) begin
            if (idle) begin
                m_ri = ~m_ri;
                m_state = 0;
            end
        end else if (rdy) begin
            if (m_state == 0) begin
                if (trig) begin
                    e.we = 1'b1;
                    e.addr = {~m_ri, 8'd0};
                    m_idx = 8'd1;
                    m_ph = 1 % DEC;
                    m_state = 1;
                end
            end else begin
                if (m_ph == 0) begin
                    e.we = 1'b1;
                    e.addr = {~m_ri, m_idx};
                    if (m_idx == 8'd255) m_state = 2;
                    m_idx = m_idx + 8'd1;
                end
                m_ph = (m_ph + 1) % DEC;
            end
        end
        e.ri = m_ri;
        if (rdy) m_prev = s;
        sb.push_back(e);
        bus.new_sample_ready = rdy;
        bus.new_sample_in = s;
        bus.wave_display_idle = idle;
        @(posedge clk);
        #1;
        bus.new_sample_ready = 1'b0;
        bus.wave_display_idle = 1'b0;
        e = sb.pop_front();
        chk("sb_we", bus.write_enable, e.we);
        chk("sb_ri", bus.read_index, e.ri);
        if (e.we) begin
            chk("sb_addr", bus.write_address, e.addr);
            chk("sb_data", bus.write_sample, e.data);
        end
        if (bus.write_enable) begin
            n_writes++;
            last_addr = bus.write_address;
        end
    endtask

    vec_t tbl[8];

    initial begin
        n_chk = 0;
        n_fail = 0;
        n_writes = 0;
        reset = 1'b1;
        bus.new_sample_ready = 1'b0;
        bus.new_sample_in = '0;
        bus.wave_display_idle = 1'b0;
        async_reset();

        // T1: reset while a capture has just written
        step(1'b1, 16'hFFFB, 1'b0);
        step(1'b1, 16'h0300, 1'b0);
        chk("t1_pre_we", bus.write_enable, 1);
        chk("t1_pre_data", bus.write_sample, 8'h83);
        async_reset();

        // T1 tail and T2: positives after reset do not trigger; -1 -> 0 does
        tbl[0] = '{1'b1, 16'd100,  1'b0, 1'b0, 9'h000, 8'h00};
        tbl[1] = '{1'b1, 16'd200,  1'b0, 1'b0, 9'h000, 8'h00};
        tbl[2] = '{1'b0, 16'd0,    1'b0, 1'b0, 9'h000, 8'h00};
        tbl[3] = '{1'b1, 16'hFF9C, 1'b1, 1'b0, 9'h000, 8'h00};
        tbl[4] = '{1'b1, 16'hFFFF, 1'b0, 1'b0, 9'h000, 8'h00};
        tbl[5] = '{1'b1, 16'd0,    1'b0, 1'b1, 9'h100, 8'h80};
        tbl[6] = '{1'b1, 16'd5,    1'b0, 1'b1, 9'h101, 8'h80};
        tbl[7] = '{1'b0, 16'd0,    1'b1, 1'b0, 9'h000, 8'h00};
        for (int i = 0; i < 8; i++) begin
            step(tbl[i].rdy, tbl[i].s, tbl[i].idle);
            chk("tbl_we", bus.write_enable, tbl[i].we);
            if (tbl[i].we) begin
                chk("tbl_addr", bus.write_address, tbl[i].addr);
                chk("tbl_data", bus.write_sample, tbl[i].data);
            end
        end

        async_reset();
        step(1'b1, 16'hFFFF, 1'b0);
        n_writes = 0;
        step(1'b1, 16'h0000, 1'b0);
`ifdef WAVE_CAPTURE_DECIMATE_EN
        // T6: sample k carries k<<6, so written sample 4i has data[6:0] == i
        for (int k = 1; k < 1024; k++) begin
            step(1'b1, 16'(k << 6), 1'b0);
            if (bus.write_enable)
                chk("t6_index", {25'd0, bus.write_sample[6:0]}, {24'd0, bus.write_address[7:0]} & 32'h7F);
        end
        chk("t6_writes", n_writes, 256);
`else
        // T3: 300 strobes after the trigger, with random gaps and back-to-back runs
        for (int k = 0; k < 300; k++) begin
            while ($urandom_range(0, 3) == 0) step(1'b0, 16'($urandom), 1'b0);
            step(1'b1, 16'($urandom), 1'b0);
        end
        chk("t3_writes", n_writes, 256);
`endif
        chk("fill_last", last_addr, 9'h1FF);
        for (int k = 0; k < 5; k++) step(1'b1, 16'hFFFF, 1'b0);
        chk("wait_nowrite", n_writes, 256);

        // T4: idle with a simultaneous strobe hands over, no trigger from it
        step(1'b1, 16'hFFFF, 1'b1);
        chk("t4_ri", bus.read_index, 1);
        chk("t4_we", bus.write_enable, 0);
        step(1'b1, 16'h0000, 1'b0);
        chk("t4_we2", bus.write_enable, 1);
        chk("t4_addr", bus.write_address, 9'h000);
        step(1'b1, 16'h0700, 1'b1);
        chk("t4_ri_hold", bus.read_index, 1);

        // T5: abandon a capture at index 100
        for (int k = 0; k < (98 * DEC); k++) step(1'b1, 16'(k), 1'b0);
        async_reset();
        chk("t5_ri", bus.read_index, 0);
        step(1'b1, 16'hFFFF, 1'b0);
        step(1'b1, 16'h0100, 1'b0);
        chk("t5_we", bus.write_enable, 1);
        chk("t5_addr", bus.write_address, 9'h100);
        chk("t5_data", bus.write_sample, 8'h81);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
